// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared flag indices and exponent class decode
// for the parametrised floating-point multiplier.
package fp_mult_pkg;

  localparam int FLG_OVF = 2;
  localparam int FLG_UDF = 1;
  localparam int FLG_ZIN = 0;

  localparam int EXP_W_DEF = 5;

  typedef struct packed {
    logic zero;
    logic inf;
  } fp_class_t;

  function automatic logic [31:0] exp_ones(input int ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

  // Denormals decode as zero and NaNs as inf.
  function automatic fp_class_t fp_class(
    input logic [31:0] e,
    input int          ew
  );
    fp_class_t c;
    c.zero = (e == 32'd0);
    c.inf  = (e == exp_ones(ew));
    return c;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise (S2) and round/pack (S3) logic.
// Round-to-nearest-even when FP_MULT_ROUND_NEAREST_EN is defined.
module fp_norm_round
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [2*MAN_W+1:0]      prod_i,
  input  logic signed [EXP_W+1:0] exp_i,
  output logic [MAN_W-1:0]        nman_o,
  output logic                    nguard_o,
  output logic                    nsticky_o,
  output logic signed [EXP_W+1:0] nexp_o,
  input  logic                    sign_i,
  input  logic signed [EXP_W+1:0] rexp_i,
  input  logic [MAN_W-1:0]        rman_i,
  input  logic                    rguard_i,
  input  logic                    rsticky_i,
  input  logic                    zero_i,
  input  logic                    inf_i,
  output logic [EXP_W+MAN_W:0]    result_o,
  output logic [2:0]              flags_o
);

  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EONES =
    EXP_W'(exp_ones(EXP_W));
  localparam logic signed [XW-1:0] EMAX =
    XW'(exp_ones(EXP_W));

  logic                 inc;
  logic [MAN_W:0]       msum;
  logic signed [XW-1:0] rexp;

  // Bring the product back to 1.x form.
  always_comb begin
    nexp_o    = exp_i;
    nman_o    = prod_i[2*MAN_W-1:MAN_W];
    nguard_o  = prod_i[MAN_W-1];
    nsticky_o = |prod_i[MAN_W-2:0];
    if (prod_i[2*MAN_W+1]) begin
      nexp_o    = exp_i + XW'(1);
      nman_o    = prod_i[2*MAN_W:MAN_W+1];
      nguard_o  = prod_i[MAN_W];
      nsticky_o = |prod_i[MAN_W-1:0];
    end
  end

`ifdef FP_MULT_ROUND_NEAREST_EN
  assign inc = rguard_i & (rsticky_i | rman_i[0]);
`else
  logic unused_gs;
  assign unused_gs = rguard_i ^ rsticky_i;
  assign inc = 1'b0;
`endif

  assign msum = {1'b0, rman_i} + {{MAN_W{1'b0}}, inc};
  assign rexp = rexp_i + {{(XW-1){1'b0}}, msum[MAN_W]};

  // Special cases first, then range checks, then pack.
  always_comb begin
    result_o = {sign_i, rexp[EXP_W-1:0], msum[MAN_W-1:0]};
    flags_o  = 3'b000;
    if (zero_i) begin
      result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_ZIN] = 1'b1;
    end else if (inf_i) begin
      result_o = {sign_i, EONES, {MAN_W{1'b0}}};
    end else if (!rexp[XW-1] && rexp >= EMAX) begin
      result_o = {sign_i, EONES, {MAN_W{1'b0}}};
      flags_o[FLG_OVF] = 1'b1;
    end else if (rexp[XW-1] || rexp == XW'(0)) begin
      result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_UDF] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined FP multiplier, valid/ready.
// Optional rounding: FP_MULT_ROUND_NEAREST_EN (else truncate).
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = 10,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [2:0]               out_flags,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2*MAN_W + 2;
  localparam int XW = EXP_W + 2;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  fp_class_t        ca, cb;

  assign ea = in_a[W-2:MAN_W];
  assign eb = in_b[W-2:MAN_W];
  assign ma = in_a[MAN_W-1:0];
  assign mb = in_b[MAN_W-1:0];
  assign ca = fp_class(32'(ea), EXP_W);
  assign cb = fp_class(32'(eb), EXP_W);

  logic                 s1_s_d;
  logic signed [XW-1:0] s1_e_d;
  logic [PW-1:0]        s1_p_d;

  assign s1_s_d = in_a[W-1] ^ in_b[W-1];
  assign s1_e_d = XW'(ea) + XW'(eb) - XW'(BIAS);
  assign s1_p_d = PW'({1'b1, ma}) * PW'({1'b1, mb});

  logic                 s1_v_q, s1_s_q;
  logic signed [XW-1:0] s1_e_q;
  logic [PW-1:0]        s1_p_q;
  logic [3:0]           s1_c_q;

  // S1: decode, exponent sum, mantissa product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_s_q <= 1'b0;
      s1_e_q <= '0;
      s1_p_q <= '0;
      s1_c_q <= '0;
    end else if (!stall) begin
      s1_v_q <= in_valid;
      s1_s_q <= s1_s_d;
      s1_e_q <= s1_e_d;
      s1_p_q <= s1_p_d;
      s1_c_q <= {ca.inf, ca.zero, cb.inf, cb.zero};
    end
  end

  logic [MAN_W-1:0]     s2_m_d;
  logic                 s2_g_d, s2_t_d;
  logic signed [XW-1:0] s2_e_d;

  logic                 s2_v_q, s2_s_q;
  logic signed [XW-1:0] s2_e_q;
  logic [MAN_W-1:0]     s2_m_q;
  logic                 s2_g_q, s2_t_q;
  logic                 s2_z_q, s2_i_q;

  logic [W-1:0]         res_d;
  logic [2:0]           flg_d;

  fp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_nr (
    .prod_i    (s1_p_q),
    .exp_i     (s1_e_q),
    .nman_o    (s2_m_d),
    .nguard_o  (s2_g_d),
    .nsticky_o (s2_t_d),
    .nexp_o    (s2_e_d),
    .sign_i    (s2_s_q),
    .rexp_i    (s2_e_q),
    .rman_i    (s2_m_q),
    .rguard_i  (s2_g_q),
    .rsticky_i (s2_t_q),
    .zero_i    (s2_z_q),
    .inf_i     (s2_i_q),
    .result_o  (res_d),
    .flags_o   (flg_d)
  );

  // S2: normalised mantissa with guard/sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q <= 1'b0;
      s2_s_q <= 1'b0;
      s2_e_q <= '0;
      s2_m_q <= '0;
      s2_g_q <= 1'b0;
      s2_t_q <= 1'b0;
      s2_z_q <= 1'b0;
      s2_i_q <= 1'b0;
    end else if (!stall) begin
      s2_v_q <= s1_v_q;
      s2_s_q <= s1_s_q;
      s2_e_q <= s2_e_d;
      s2_m_q <= s2_m_d;
      s2_g_q <= s2_g_d;
      s2_t_q <= s2_t_d;
      s2_z_q <= s1_c_q[2] | s1_c_q[0];
      s2_i_q <= s1_c_q[3] | s1_c_q[1];
    end
  end

  // S3: rounded, packed result held for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (!stall) begin
      out_valid  <= s2_v_q;
      out_result <= res_d;
      out_flags  <= flg_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: random and directed checks of fp_mult_pipe
// against an integer-arithmetic reference model.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_a, in_b;
  logic        in_valid, in_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;
  logic        out_valid, out_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [18:0] sb[$];

  always #5 clk = ~clk;

  fp_mult_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Half precision: value = 1.m * 2^(e-15), computed on integers.
  function automatic logic [18:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    int ea, eb, ma, mb, p, e, sh, m;
    logic s;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = int'(a[9:0]);
    mb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    if (ea == 0 || eb == 0) return {s, 15'h0, 3'b001};
    if (ea == 31 || eb == 31) return {s, 5'h1f, 10'h0, 3'b000};
    p  = (1024 + ma) * (1024 + mb);
    e  = ea + eb - 15;
    sh = (p >= (1 << 21)) ? 11 : 10;
    e  = e + sh - 10;
    m  = p >> sh;
`ifdef FP_MULT_ROUND_NEAREST_EN
    begin
      int rem, half;
      rem  = p - (m << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (m % 2) == 1)) m++;
    end
`endif
    if (m == 2048) begin
      m = 1024;
      e++;
    end
    if (e >= 31) return {s, 5'h1f, 10'h0, 3'b100};
    if (e <= 0) return {s, 15'h0, 3'b010};
    return {s, 5'(e), 10'(m - 1024), 3'b000};
  endfunction

  // Scoreboard, handshake and stall-stability compare.
  initial begin
    logic        hold_v;
    logic [18:0] hold_r;
    logic [18:0] req;
    hold_v = 1'b0;
    hold_r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v)
          check("stall_hold",
                {out_valid, out_result, out_flags},
                {1'b1, hold_r});
        hold_v = out_valid && !out_ready;
        hold_r = {out_result, out_flags};
        if (out_valid)
          check("in_ready", in_ready, !(out_valid && !out_ready));
        if (in_valid && in_ready)
          sb.push_back(model(in_a, in_b));
        if (out_valid && out_ready) begin
          n_out++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_out: got %h want none",
                     {out_result, out_flags});
          end else begin
            req = sb.pop_front();
            check("stream", {out_result, out_flags}, req);
          end
        end
      end
    end
  end

  task automatic rnd_ops();
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    if ($urandom_range(0, 1) == 1) a[14:10] = 5'($urandom_range(8, 22));
    if ($urandom_range(0, 1) == 1) b[14:10] = 5'($urandom_range(8, 22));
    in_a = a;
    in_b = b;
  endtask

  task automatic direct(input string nm,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [15:0] rr,
                        input logic [2:0]  rf);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_lat2"}, out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_lat3"}, out_valid, 1'b1);
    check({nm, "_res"}, out_result, rr);
    check({nm, "_flg"}, out_flags, rf);
  endtask

  // st0 < 0: random valid/ready; otherwise 5-cycle stall at st0.
  task automatic stream(input string nm, input int n, input int st0);
    int sent, cyc, o0;
    bit acc;
    sent = 0;
    cyc  = 0;
    o0   = n_out;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rnd_ops();
    in_valid = 1'b1;
    while (sent < n && cyc < 20000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc || !in_valid) begin
        if (acc) sent++;
        if (sent < n) begin
          if (acc) rnd_ops();
          in_valid = (st0 >= 0) || ($urandom_range(0, 3) != 0);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (st0 < 0) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(cyc >= st0 && cyc < st0 + 5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({nm, "_sent"}, sent, n);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check({nm, "_count"}, n_out - o0, n);
    check({nm, "_empty"}, sb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    in_a = '0;
    in_b = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_result", out_result, 16'h0);
    check("rst_flags", out_flags, 3'b000);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    check("pin_mul15", model(16'h3E00, 16'h3E00), {16'h4080, 3'b000});
    check("pin_neg", model(16'hBC00, 16'h4000), {16'hC000, 3'b000});
    check("pin_ovf", model(16'h7BFF, 16'h4000), {16'h7C00, 3'b100});
    check("pin_udf", model(16'h0400, 16'h3800), {16'h0000, 3'b010});
    check("pin_zinf", model(16'h0000, 16'h7C00), {16'h0000, 3'b001});

    direct("mul15", 16'h3E00, 16'h3E00, 16'h4080, 3'b000);
    direct("neg", 16'hBC00, 16'h4000, 16'hC000, 3'b000);
    direct("ovf", 16'h7BFF, 16'h4000, 16'h7C00, 3'b100);
    direct("udf", 16'h0400, 16'h3800, 16'h0000, 3'b010);
    direct("zinf", 16'h0000, 16'h7C00, 16'h0000, 3'b001);
    direct("denorm", 16'h8001, 16'h3C00, 16'h8000, 3'b001);
    direct("inf", 16'h7C00, 16'hC000, 16'hFC00, 3'b000);
`ifdef FP_MULT_ROUND_NEAREST_EN
    direct("round", 16'h3C05, 16'h3E00, 16'h3E08, 3'b000);
`else
    direct("round", 16'h3C05, 16'h3E00, 16'h3E07, 3'b000);
`endif

    stream("bp", 8, 3);
    stream("rand", 300, -1);

    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rnd_ops();
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      rnd_ops();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("kill_valid", out_valid, 1'b0);
    check("kill_result", out_result, 16'h0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    direct("post_rst", 16'h3E00, 16'h3E00, 16'h4080, 3'b000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("post_rst_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, fully pipelined IEEE-style floating-point multiplier. Generalises the fixed 16-bit two-stage multiplier to arbitrary exponent and mantissa widths.
- Adds a valid/ready handshake with backpressure, special-case handling, overflow/underflow flags and optional round-to-nearest-even.
- Sits between the neuron weight/activation datapath and the accumulator.
- Accepts one operand pair per cycle.

Parameters:
- EXP_W, 5, exponent field width (≥3).
- MAN_W, 10, stored mantissa width (hidden bit excluded, ≥2).
- BIAS, 2**(EXP_W-1)-1, exponent bias.
- Derived (localparam): W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_a  in  W  operand A {sign, exp, man}.
- in_b  in  W  operand B.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept this cycle.
- out_result  out  W  product.
- out_flags  out  3  {overflow, underflow, zero_or_denorm_input}.
- out_valid  out  1  out_result/out_flags valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset: all pipeline valid bits, out_valid, out_result and out_flags are 0. in_ready is 1 one cycle after reset deassertion.
- Reset is asynchronous and kills in-flight data; no partial result ever appears.
- Pipeline: 3 register stages (S1, S2, S3). Latency is exactly 3 cycles from an accepted input to out_valid, absent stalls.
- Stall: stall = out_valid & ~out_ready.
  - On stall, all stages hold their contents.
  - in_ready = ~stall. Transfer occurs when in_valid & in_ready.
  - Bubbles are not squeezed during a stall.
  - out_result and out_flags are stable while out_valid & ~out_ready.
- S1 (decode and multiply):
  - sign = a.s ^ b.s.
  - Exponent sum computed signed, EXP_W+2 bits: ea + eb - BIAS.
  - Mantissa product {1,ma}*{1,mb}, 2*MAN_W+2 bits.
  - Class bits registered: a_zero (exp==0, so denormals are flushed to zero), a_inf (exp all ones; NaN is treated as inf), and the same for b.
- S2 (normalise):
  - If product MSB is 1, shift right by 1 and add 1 to the exponent.
  - Keep MAN_W mantissa bits plus guard and sticky bits.
- S3 (round and pack), in priority order:
  - Any zero input: signed zero, flag[0]=1. This also covers zero×inf; the block has no NaN output.
  - Any inf input: signed inf (exp all ones, man 0).
  - Exponent ≥ 2^EXP_W-1 after rounding: signed inf, flag[2]=1.
  - Exponent ≤ 0: signed zero, flag[1]=1.
  - Otherwise: normal pack.
- Rounding carry: if rounding carries out of the mantissa, the mantissa becomes 0, the exponent increments by 1, and the overflow check is re-applied.
- Simultaneous in_valid and stall: input is not accepted; upstream must hold.

Optional Feature:
- Macro: FP_MULT_ROUND_NEAREST_EN.
- Defined: round-to-nearest, ties-to-even, using guard and sticky bits.
- Undefined: truncate toward zero; guard and sticky are discarded. Matches legacy multiplier numerics.
- Latency is identical in both builds.

Decomposition:
- Package fp_mult_pkg holds:
  - flag index constants FLG_OVF=2, FLG_UDF=1, FLG_ZIN=0;
  - a class-decode function (is_zero/is_inf from EXP_W);
  - the localparam for the all-ones exponent.
- One sub-module, fp_norm_round, is natural: S2/S3 normalise, round, overflow/underflow and pack logic, parametrised by EXP_W and MAN_W.
- The top level holds the S1 multiply, pipeline registers and handshake.

Test Plan:
- Default params, no stall: 0x3E00×0x3E00 (1.5×1.5) gives 0x4080 with flags 000 exactly 3 cycles later; 0xBC00×0x4000 gives 0xC000.
- Overflow: 0x7BFF×0x4000 gives 0x7C00, flag[2]=1. Underflow: 0x0400×0x3800 gives 0x0000, flag[1]=1.
- Special cases:
  - 0x0000×0x7C00 gives 0x0000, flag[0]=1.
  - 0x8001 (denormal) × 0x3C00 gives 0x8000, flag[0]=1.
  - 0x7C00×0xC000 gives 0xFC00.
- Rounding, 0x3C05×0x3E00: 0x3E08 with FP_MULT_ROUND_NEAREST_EN, 0x3E07 without.
- Backpressure: stream 8 back-to-back products and hold out_ready=0 for 5 cycles mid-stream. Required: no loss or duplication, in_ready low throughout the stall, outputs stable, order preserved.
- Reset mid-stream: assert rst with 3 ops in flight. Required: out_valid=0 immediately; after release, a new op yields only its own result at latency 3.
